// File: rtl/led_pattern_sequencer_pkg.sv
// rtl/led_pattern_sequencer_pkg.sv - shared types and widths for the LED pattern sequencer
package led_pattern_sequencer_pkg;

  localparam int DUR_W   = 16;
  localparam int COLOR_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [DUR_W-1:0]   duration;
    logic               last;
  } entry_t;

endpackage

// File: rtl/led_pattern_sequencer_tick.sv
// rtl/led_pattern_sequencer_tick.sv - step-timing prescaler emitting one tick every DIV cycles
module tick_divider #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Tick only while counting; a held clear keeps the counter parked at the reload value.
  assign tick_o = !clear_i && (count_q == '0);

  // Down-count with reload on zero or on clear.
  always_comb begin
    count_d = count_q;
    if (clear_i || (count_q == '0)) begin
      count_d = RELOAD;
    end else begin
      count_d = count_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - table-driven RGB LED pattern player with tick-based step timing
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int CLOCK_SPEED = 12000000,
  parameter int TICK_HZ     = 1000,
  parameter int STEPS       = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [$clog2(STEPS)-1:0] cfg_addr_i,
  input  logic [COLOR_W-1:0]       cfg_color_i,
  input  logic [DUR_W-1:0]         cfg_duration_i,
  input  logic                     cfg_last_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  output logic                     busy_o,
  output logic [$clog2(STEPS)-1:0] step_o,
  output logic                     wrap_o,
  output logic [COLOR_W-1:0]       led_rgb_o
);

  localparam int DIV = CLOCK_SPEED / TICK_HZ;
  localparam int AW  = $clog2(STEPS);
  localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      step_q, step_d;
  logic [COLOR_W-1:0] led_q, led_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic               wrap_q, wrap_d;

  entry_t             table_q [STEPS];
  entry_t             cur_entry;
  entry_t             nxt_entry;
  logic               wrap_sel;
  logic [AW-1:0]      nxt_step;
  logic               tick;

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == RUN);
  assign step_o      = step_q;
  assign wrap_o      = wrap_q;
  assign led_rgb_o   = led_q;

  // Prescaler is held in reload while idle so the first step gets a full tick period.
  tick_divider #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

  assign cur_entry = table_q[step_q];
  assign wrap_sel  = cur_entry.last || (step_q == LAST_STEP);
  assign nxt_step  = wrap_sel ? '0 : (step_q + AW'(1));
  assign nxt_entry = table_q[nxt_step];

  // Pattern table: reset to dark, zero-length, single-entry patterns; writable only when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STEPS; i++) begin
        table_q[i] <= '{color: '0, duration: '0, last: 1'b1};
      end
    end else if (cfg_valid_i && cfg_ready_o) begin
      table_q[cfg_addr_i] <= '{color: cfg_color_i, duration: cfg_duration_i, last: cfg_last_i};
    end
  end

  // Next-state and output logic; a remaining count of 0 or 1 both advance, so duration 0 plays as 1 tick.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    led_d   = led_q;
    rem_d   = rem_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        step_d = '0;
        led_d  = '1;
        if (start_i) begin
          state_d = RUN;
          led_d   = ~table_q[0].color;
          rem_d   = table_q[0].duration;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
          step_d  = '0;
          led_d   = '1;
        end else if (tick) begin
          if (rem_q > DUR_W'(1)) begin
            rem_d = rem_q - DUR_W'(1);
          end else begin
            step_d = nxt_step;
            led_d  = ~nxt_entry.color;
            rem_d  = nxt_entry.duration;
            wrap_d = wrap_sel;
          end
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        led_d   = '1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      led_q   <= '1;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      led_q   <= led_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for the LED pattern sequencer
module tb_led_pattern_sequencer;

  localparam int STEPS = 4;
  localparam int DIV   = 10;

  typedef struct packed {
    logic [15:0] m;
    logic [2:0]  led;
    logic [1:0]  step;
    logic        wrap;
    logic        busy;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [1:0]  cfg_addr_i;
  logic [2:0]  cfg_color_i;
  logic [15:0] cfg_duration_i;
  logic        cfg_last_i;
  logic        start_i;
  logic        stop_i;
  logic        busy_o;
  logic [1:0]  step_o;
  logic        wrap_o;
  logic [2:0]  led_rgb_o;

  logic [2:0]  m_color [STEPS];
  logic [15:0] m_dur   [STEPS];
  logic        m_last  [STEPS];

  obs_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer #(
    .CLOCK_SPEED (10),
    .TICK_HZ     (1),
    .STEPS       (STEPS)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_valid_i    (cfg_valid_i),
    .cfg_ready_o    (cfg_ready_o),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_color_i    (cfg_color_i),
    .cfg_duration_i (cfg_duration_i),
    .cfg_last_i     (cfg_last_i),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .busy_o         (busy_o),
    .step_o         (step_o),
    .wrap_o         (wrap_o),
    .led_rgb_o      (led_rgb_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < STEPS; i++) begin
      m_color[i] = 3'b000;
      m_dur[i]   = 16'd0;
      m_last[i]  = 1'b1;
    end
  endtask

  // Expected outputs m cycles after the start edge, walking the bench's copy of the table.
  function automatic obs_t model_at(input int m);
    obs_t o;
    int t = 0;
    int s = 0;
    int len;
    len = DIV * ((m_dur[s] == 16'd0) ? 1 : int'(m_dur[s]));
    while (m >= t + len) begin
      t += len;
      s = (m_last[s] || s == STEPS - 1) ? 0 : s + 1;
      len = DIV * ((m_dur[s] == 16'd0) ? 1 : int'(m_dur[s]));
    end
    o.m    = 16'(m);
    o.led  = ~m_color[s];
    o.step = 2'(s);
    o.wrap = (s == 0) && (t > 0) && (m == t);
    o.busy = 1'b1;
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check_val($sformatf("led m=%0d", e.m), {29'd0, led_rgb_o}, {29'd0, e.led});
      check_val($sformatf("step m=%0d", e.m), {30'd0, step_o}, {30'd0, e.step});
      check_val($sformatf("wrap m=%0d", e.m), {31'd0, wrap_o}, {31'd0, e.wrap});
      check_val($sformatf("busy m=%0d", e.m), {31'd0, busy_o}, {31'd0, e.busy});
    end
  end

  task automatic cfg_write(input logic [1:0] addr, input logic [2:0] color, input logic [15:0] dur,
                           input logic last, input logic expect_ready);
    @(negedge clk);
    cfg_valid_i    = 1'b1;
    cfg_addr_i     = addr;
    cfg_color_i    = color;
    cfg_duration_i = dur;
    cfg_last_i     = last;
    check_val("cfg_ready", {31'd0, cfg_ready_o}, {31'd0, expect_ready});
    if (expect_ready) begin
      m_color[addr] = color;
      m_dur[addr]   = dur;
      m_last[addr]  = last;
    end
    @(posedge clk);
    #1 cfg_valid_i = 1'b0;
  endtask

  task automatic start_trace(input int n);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int m = 0; m < n; m++) exp_q.push_back(model_at(m));
    for (int k = 0; k < n + 5 && exp_q.size() > 0; k++) @(negedge clk);
    check_val("trace_drain", exp_q.size(), 0);
  endtask

  task automatic stop_run(input logic with_start);
    @(negedge clk);
    stop_i  = 1'b1;
    start_i = with_start;
    @(posedge clk);
    #1;
    stop_i  = 1'b0;
    start_i = 1'b0;
    check_val("stop_busy", {31'd0, busy_o}, 0);
    check_val("stop_led", {29'd0, led_rgb_o}, 32'h7);
    check_val("stop_step", {30'd0, step_o}, 0);
    check_val("stop_ready", {31'd0, cfg_ready_o}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    cfg_valid_i    = 1'b0;
    cfg_addr_i     = '0;
    cfg_color_i    = '0;
    cfg_duration_i = '0;
    cfg_last_i     = 1'b0;
    start_i        = 1'b0;
    stop_i         = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_val("rst_led", {29'd0, led_rgb_o}, 32'h7);
    check_val("rst_ready", {31'd0, cfg_ready_o}, 1);
    check_val("rst_busy", {31'd0, busy_o}, 0);
    check_val("rst_wrap", {31'd0, wrap_o}, 0);
    check_val("rst_step", {30'd0, step_o}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_led", {29'd0, led_rgb_o}, 32'h7);

    // Default table: dark LED, wrap every tick.
    start_trace(35);
    stop_run(1'b0);

    // Two-entry pattern: 110 for two ticks, 101 for one, then back.
    cfg_write(2'd0, 3'b001, 16'd2, 1'b0, 1'b1);
    cfg_write(2'd1, 3'b010, 16'd1, 1'b1, 1'b1);
    start_trace(45);
    stop_run(1'b0);

    // Four entries, none marked last: wrap only from 3 to 0.
    cfg_write(2'd0, 3'b011, 16'd1, 1'b0, 1'b1);
    cfg_write(2'd1, 3'b100, 16'd1, 1'b0, 1'b1);
    cfg_write(2'd2, 3'b101, 16'd0, 1'b0, 1'b1);
    cfg_write(2'd3, 3'b110, 16'd1, 1'b0, 1'b1);
    start_trace(45);

    // Writes while running are refused and stop beats start.
    cfg_write(2'd0, 3'b111, 16'd3, 1'b1, 1'b0);
    stop_run(1'b1);
    start_trace(25);

    // Asynchronous reset five cycles into step 1.
    stop_run(1'b0);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    check_val("pre_rst_step", {30'd0, step_o}, 1);
    check_val("pre_rst_busy", {31'd0, busy_o}, 1);
    reset_n = 1'b0;
    #1;
    check_val("async_led", {29'd0, led_rgb_o}, 32'h7);
    check_val("async_busy", {31'd0, busy_o}, 0);
    check_val("async_step", {30'd0, step_o}, 0);
    check_val("async_wrap", {31'd0, wrap_o}, 0);
    check_val("async_ready", {31'd0, cfg_ready_o}, 1);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start_trace(25);
    stop_run(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
